vec_inst_dispatcher: RTL and testbench

//  Synthesizable issue front-end between scalar core and vector_processor.

---
 rtl/vec_inst_dispatcher.sv | 223 ++++++++++++++++++++++
 tb/tb_vec_inst_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_inst_dispatcher.sv
// Issue front-end between the scalar core and the vector processor: in-order instruction
// queue, single-outstanding issue handshake with watchdog, and a tagged response FIFO.
module vec_inst_dispatcher #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned RSP_DEPTH = 4,
   parameter int unsigned TAG_W     = 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [XLEN-1:0]          enq_inst,
   input  logic [XLEN-1:0]          enq_rs1,
   input  logic [XLEN-1:0]          enq_rs2,
   input  logic                     flush,
   output logic [XLEN-1:0]          instruction,
   output logic [XLEN-1:0]          rs1_data,
   output logic [XLEN-1:0]          rs2_data,
   output logic                     inst_valid,
   input  logic                     vec_pro_ready,
   input  logic                     vec_pro_ack,
   input  logic                     is_vec,
   input  logic                     error,
   input  logic [XLEN-1:0]          csr_out,
   output logic                     scalar_pro_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic                     rsp_is_vec,
   output logic                     rsp_error,
   output logic                     rsp_timeout,
   output logic [XLEN-1:0]          rsp_csr,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     busy
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned RAW = $clog2(RSP_DEPTH);
   localparam int unsigned RCW = RAW + 1;

   typedef enum logic [2:0] {StIdle, StWaitRdy, StIssue, StWaitAck, StHshake} state_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             is_vec;
      logic             error;
      logic             timeout;
      logic [XLEN-1:0]  csr;
   } rsp_t;

   state_e state_q, state_d;

   logic [XLEN-1:0] q_inst_q [DEPTH];
   logic [XLEN-1:0] q_rs1_q  [DEPTH];
   logic [XLEN-1:0] q_rs2_q  [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   cnt_q;
   logic            enq, deq;

   logic [XLEN-1:0] inst_q, rs1_q, rs2_q;
   logic [TAG_W-1:0] tag_q;
   logic            tag_inc;
   logic [31:0]     wd_q, wd_d;

   rsp_t            rsp_mem_q [RSP_DEPTH];
   logic [RAW-1:0]  rwptr_q, rrptr_q;
   logic [RCW-1:0]  rcnt_q;
   logic            rsp_push, rsp_pop, push_timeout;
   rsp_t            rsp_new, rsp_head;

   // Ready also while full if the head leaves this same cycle.
   assign enq_ready = (cnt_q != CW'(DEPTH)) || deq;
   assign enq       = enq_valid && enq_ready && !flush;

   always_ff @(posedge clk) begin
      if (enq) begin
         q_inst_q[wptr_q] <= enq_inst;
         q_rs1_q[wptr_q]  <= enq_rs1;
         q_rs2_q[wptr_q]  <= enq_rs2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         rptr_q <= wptr_q;
         cnt_q  <= '0;
      end else begin
         if (enq) wptr_q <= wptr_q + 1'b1;
         if (deq) rptr_q <= rptr_q + 1'b1;
         if (enq && !deq) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (!enq && deq) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      deq          = 1'b0;
      rsp_push     = 1'b0;
      push_timeout = 1'b0;
      tag_inc      = 1'b0;
      wd_d         = wd_q;
      unique case (state_q)
         StIdle: begin
            // A response slot is reserved here so the later push cannot overflow.
            if (!flush && cnt_q != '0 && rcnt_q != RCW'(RSP_DEPTH)) state_d = StWaitRdy;
         end
         StWaitRdy: begin
            if (flush || cnt_q == '0) begin
               state_d = StIdle;
            end else if (vec_pro_ready) begin
               deq     = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            wd_d    = '0;
            state_d = StWaitAck;
         end
         StWaitAck: begin
            if (vec_pro_ack) begin
               rsp_push = 1'b1;
               state_d  = StHshake;
            end else if (TIMEOUT != 0 && wd_q == TIMEOUT - 1) begin
               rsp_push     = 1'b1;
               push_timeout = 1'b1;
               tag_inc      = 1'b1;
               state_d      = StIdle;
            end else begin
               wd_d = wd_q + 1;
            end
         end
         StHshake: begin
            if (!vec_pro_ack) begin
               tag_inc = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         wd_q    <= '0;
         tag_q   <= '0;
         inst_q  <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         if (tag_inc) tag_q <= tag_q + 1'b1;
         if (deq) begin
            inst_q <= q_inst_q[rptr_q];
            rs1_q  <= q_rs1_q[rptr_q];
            rs2_q  <= q_rs2_q[rptr_q];
         end
      end
   end

   always_comb begin
      rsp_new     = '0;
      rsp_new.tag = tag_q;
      if (push_timeout) begin
         rsp_new.error   = 1'b1;
         rsp_new.timeout = 1'b1;
      end else begin
         rsp_new.is_vec = is_vec;
         rsp_new.error  = error;
         rsp_new.csr    = csr_out;
      end
   end

   assign rsp_valid = (rcnt_q != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rwptr_q <= '0;
         rrptr_q <= '0;
         rcnt_q  <= '0;
         for (int i = 0; i < int'(RSP_DEPTH); i++) rsp_mem_q[i] <= '0;
      end else begin
         if (rsp_push) begin
            rsp_mem_q[rwptr_q] <= rsp_new;
            rwptr_q            <= rwptr_q + 1'b1;
         end
         if (rsp_pop) rrptr_q <= rrptr_q + 1'b1;
         if (rsp_push && !rsp_pop) begin
            rcnt_q <= rcnt_q + 1'b1;
         end else if (!rsp_push && rsp_pop) begin
            rcnt_q <= rcnt_q - 1'b1;
         end
      end
   end

   assign rsp_head         = rsp_mem_q[rrptr_q];
   assign rsp_tag          = rsp_head.tag;
   assign rsp_is_vec       = rsp_head.is_vec;
   assign rsp_error        = rsp_head.error;
   assign rsp_timeout      = rsp_head.timeout;
   assign rsp_csr          = rsp_head.csr;

   assign instruction      = inst_q;
   assign rs1_data         = rs1_q;
   assign rs2_data         = rs2_q;
   assign inst_valid       = (state_q == StIssue);
   assign scalar_pro_ready = (state_q == StHshake);
   assign q_count          = cnt_q;
   assign busy             = (state_q != StIdle) || (cnt_q != '0);

endmodule

// File: tb/tb_vec_inst_dispatcher.sv
// Directed bench for vec_inst_dispatcher: a scripted vector-processor responder plus
// table-driven and hand-written sequences checked against hand-computed values.
module tb_vec_inst_dispatcher;

   logic        clk = 1'b0;
   logic        reset, enq_valid, enq_ready, flush, inst_valid;
   logic [31:0] enq_inst, enq_rs1, enq_rs2, instruction, rs1_data, rs2_data, csr_out, rsp_csr;
   logic        vec_pro_ready, vec_pro_ack, is_vec, error, scalar_pro_ready;
   logic        rsp_valid, rsp_ready, rsp_is_vec, rsp_error, rsp_timeout, busy;
   logic [7:0]  rsp_tag;
   logic [3:0]  q_count;

   always #5 clk = ~clk;

   vec_inst_dispatcher #(
      .XLEN(32), .DEPTH(8), .RSP_DEPTH(4), .TAG_W(8), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_inst(enq_inst), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2), .flush(flush),
      .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .inst_valid(inst_valid), .vec_pro_ready(vec_pro_ready), .vec_pro_ack(vec_pro_ack),
      .is_vec(is_vec), .error(error), .csr_out(csr_out), .scalar_pro_ready(scalar_pro_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_is_vec(rsp_is_vec),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_csr(rsp_csr),
      .q_count(q_count), .busy(busy)
   );

   typedef struct {
      logic [31:0] inst, rs1, rs2;
      logic        exp_is_vec, exp_err;
      logic [31:0] exp_csr;
   } vec_t;

   typedef struct {
      logic [7:0]  tag;
      logic        is_vec, error, timeout;
      logic [31:0] csr;
   } rsp_rec_t;

   vec_t        tbl [8];
   rsp_rec_t    rsp_log [$];
   logic [31:0] issued [$];
   int          total = 0, bad = 0;
   int          issue_cnt = 0, dbl = 0;
   bit          iv_prev = 1'b0;
   bit          vp_auto = 1'b0;
   int          ack_delay = 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: log popped responses and issue pulses, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (rsp_valid && rsp_ready)
               rsp_log.push_back('{rsp_tag, rsp_is_vec, rsp_error, rsp_timeout, rsp_csr});
            if (inst_valid) begin
               issue_cnt++;
               issued.push_back(instruction);
               if (iv_prev) dbl++;
            end
            iv_prev = inst_valid;
         end else begin
            iv_prev = 1'b0;
         end
      end
   end

   // Vector-processor model: ack ack_delay cycles after issue, drop ack once acknowledged.
   initial begin
      logic [31:0] ci, c1, c2;
      int n;
      vec_pro_ack = 1'b0; is_vec = 1'b0; error = 1'b0; csr_out = '0;
      forever begin
         step();
         if (vp_auto && inst_valid) begin
            ci = instruction; c1 = rs1_data; c2 = rs2_data;
            repeat (ack_delay) step();
            vec_pro_ack = 1'b1;
            is_vec      = (ci[6:0] == 7'h57);
            error       = ci[31];
            csr_out     = c1 + c2;
            n = 0;
            do begin
               step();
               n++;
            end while (!scalar_pro_ready && n < 64);
            vec_pro_ack = 1'b0; is_vec = 1'b0; error = 1'b0; csr_out = '0;
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; enq_valid = 1'b0; flush = 1'b0;
      step();
      step();
      reset = 1'b0;
      rsp_log.delete();
      issued.delete();
      issue_cnt = 0;
   endtask

   task automatic enq(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
      int n = 0;
      while (!enq_ready && n < 200) begin
         step();
         n++;
      end
      enq_valid = 1'b1; enq_inst = i; enq_rs1 = r1; enq_rs2 = r2;
      step();
      enq_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int cnt, input int budget);
      int n = 0;
      while (rsp_log.size() < cnt && n < budget) begin
         step();
         n++;
      end
      chk("rsp_count", rsp_log.size(), cnt);
   endtask

   task automatic wait_issue(input int budget);
      int n = 0;
      while (!inst_valid && n < budget) begin
         step();
         n++;
      end
      chk("issue_seen", inst_valid, 1'b1);
   endtask

   initial begin
      tbl[0] = '{32'h0000_7057, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0003};
      tbl[1] = '{32'h8000_1057, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0030};
      tbl[2] = '{32'h0000_0033, 32'h0000_0100, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0105};
      tbl[3] = '{32'h8000_0013, 32'h0000_ffff, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000};
      tbl[4] = '{32'h1234_5657, 32'h0000_0007, 32'h0000_0009, 1'b1, 1'b0, 32'h0000_0010};
      tbl[5] = '{32'hfedc_ba57, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 32'h3333_3333};
      tbl[6] = '{32'h0000_006f, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000};
      tbl[7] = '{32'h7fff_ff57, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000};

      enq_inst = '0; enq_rs1 = '0; enq_rs2 = '0;
      vec_pro_ready = 1'b0; rsp_ready = 1'b0;
      reset = 1'b1; enq_valid = 1'b0; flush = 1'b0;
      step();
      step();
      chk("rst_enq_ready", enq_ready, 1'b1);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_q_count", q_count, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_spr", scalar_pro_ready, 1'b0);

      // Test 1: single instruction, issue latency and response.
      do_reset();
      vec_pro_ready = 1'b1; rsp_ready = 1'b1; vp_auto = 1'b1; ack_delay = 4;
      enq_valid = 1'b1; enq_inst = 32'h0000_7057; enq_rs1 = 32'h10; enq_rs2 = '0;
      step();
      enq_valid = 1'b0;
      chk("t1_count", q_count, 1);
      chk("t1_busy", busy, 1'b1);
      chk("t1_iv_c1", inst_valid, 1'b0);
      step();
      chk("t1_iv_c2", inst_valid, 1'b0);
      step();
      chk("t1_iv_c3", inst_valid, 1'b1);
      chk("t1_inst", instruction, 32'h0000_7057);
      chk("t1_rs1", rs1_data, 32'h10);
      step();
      chk("t1_iv_c4", inst_valid, 1'b0);
      wait_rsp(1, 50);
      if (rsp_log.size() >= 1) begin
         chk("t1_tag", rsp_log[0].tag, 0);
         chk("t1_is_vec", rsp_log[0].is_vec, 1'b1);
         chk("t1_error", rsp_log[0].error, 1'b0);
         chk("t1_csr", rsp_log[0].csr, 32'h10);
      end
      chk("t1_issues", issue_cnt, 1);

      // Test 2: fill to full, then drain in order.
      do_reset();
      vec_pro_ready = 1'b0; ack_delay = 2;
      for (int i = 0; i < 8; i++) enq(tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      chk("t2_full_count", q_count, 8);
      chk("t2_full_ready", enq_ready, 1'b0);
      vec_pro_ready = 1'b1;
      wait_rsp(8, 400);
      repeat (10) step();
      chk("t2_issues", issue_cnt, 8);
      chk("t2_nrsp", rsp_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < rsp_log.size() && i < issued.size()) begin
            chk($sformatf("t2_inst%0d", i), issued[i], tbl[i].inst);
            chk($sformatf("t2_tag%0d", i), rsp_log[i].tag, i);
            chk($sformatf("t2_vec%0d", i), rsp_log[i].is_vec, tbl[i].exp_is_vec);
            chk($sformatf("t2_err%0d", i), rsp_log[i].error, tbl[i].exp_err);
            chk($sformatf("t2_csr%0d", i), rsp_log[i].csr, tbl[i].exp_csr);
         end
      end
      chk("t2_empty", q_count, 0);

      // Test 3: response back-pressure parks the issue loop.
      do_reset();
      rsp_ready = 1'b0; ack_delay = 1;
      for (int i = 0; i < 6; i++) enq(tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      repeat (80) step();
      chk("t3_parked_issues", issue_cnt, 4);
      chk("t3_parked_count", q_count, 2);
      chk("t3_rsp_valid", rsp_valid, 1'b1);
      chk("t3_head_tag", rsp_tag, 0);
      rsp_ready = 1'b1;
      wait_rsp(6, 200);
      repeat (5) step();
      chk("t3_issues", issue_cnt, 6);
      for (int i = 0; i < 6; i++)
         if (i < rsp_log.size()) chk($sformatf("t3_tag%0d", i), rsp_log[i].tag, i);
      chk("t3_busy", busy, 1'b0);

      // Test 4: watchdog timeout, then the next entry issues.
      do_reset();
      vp_auto = 1'b0; ack_delay = 1;
      enq(32'h8000_0013, 32'h1, 32'h1);
      enq(32'h0000_7057, 32'h5, 32'h6);
      wait_issue(20);
      repeat (16) step();
      chk("t4_rsp_before", rsp_valid, 1'b0);
      step();
      chk("t4_rsp_valid", rsp_valid, 1'b1);
      chk("t4_timeout", rsp_timeout, 1'b1);
      chk("t4_error", rsp_error, 1'b1);
      chk("t4_csr", rsp_csr, 0);
      chk("t4_tag", rsp_tag, 0);
      vp_auto = 1'b1;
      wait_rsp(2, 60);
      if (rsp_log.size() >= 2) begin
         chk("t4_next_tag", rsp_log[1].tag, 1);
         chk("t4_next_to", rsp_log[1].timeout, 1'b0);
         chk("t4_next_csr", rsp_log[1].csr, 32'hb);
      end
      chk("t4_issues", issue_cnt, 2);

      // Test 5: flush during WAIT_ACK; simultaneous enqueue is dropped.
      do_reset();
      ack_delay = 8;
      for (int i = 0; i < 4; i++) enq(tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      chk("t5_issued", issue_cnt, 1);
      chk("t5_pre_count", q_count, 3);
      flush = 1'b1; enq_valid = 1'b1; enq_inst = 32'h0000_7057;
      step();
      flush = 1'b0; enq_valid = 1'b0;
      chk("t5_post_count", q_count, 0);
      wait_rsp(1, 40);
      if (rsp_log.size() >= 1) begin
         chk("t5_tag", rsp_log[0].tag, 0);
         chk("t5_csr", rsp_log[0].csr, tbl[0].exp_csr);
      end
      repeat (40) step();
      chk("t5_issues", issue_cnt, 1);
      chk("t5_busy", busy, 1'b0);

      // Test 6: reset during HSHAKE clears state and tag.
      do_reset();
      rsp_ready = 1'b0; ack_delay = 2;
      enq(tbl[0].inst, tbl[0].rs1, tbl[0].rs2);
      enq(tbl[1].inst, tbl[1].rs1, tbl[1].rs2);
      begin
         int n = 0;
         while (!scalar_pro_ready && n < 40) begin
            step();
            n++;
         end
      end
      chk("t6_in_hshake", scalar_pro_ready, 1'b1);
      reset = 1'b1;
      step();
      chk("t6_spr", scalar_pro_ready, 1'b0);
      chk("t6_rsp_valid", rsp_valid, 1'b0);
      chk("t6_count", q_count, 0);
      chk("t6_iv", inst_valid, 1'b0);
      do_reset();
      rsp_ready = 1'b1;
      enq(tbl[4].inst, tbl[4].rs1, tbl[4].rs2);
      wait_rsp(1, 40);
      if (rsp_log.size() >= 1) chk("t6_tag_after_reset", rsp_log[0].tag, 0);

      chk("no_double_issue", dbl, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
